// File: rtl/uart_rx_fifo_read_ctrl_pkg.sv
// uart_rx_fifo_read_ctrl_pkg: shared widths, word types and FSM encoding for the FIFO read controller
package uart_rx_fifo_read_ctrl_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    typedef logic [ADDR_WIDTH-1:0] ADDR_W;
    typedef logic [DATA_WIDTH-1:0] DATA_T;
    typedef logic bit_t;
    typedef enum logic [1:0] {EMPTY, WAIT_RD, FULL} rd_state_t;
endpackage

// File: rtl/uart_rx_fifo_read_ctrl.sv
// uart_rx_fifo_read_ctrl: read pointer, RAM read sequencing and one-entry output register of the UART rx FIFO
module uart_rx_fifo_read_ctrl
    import uart_rx_fifo_read_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = uart_rx_fifo_read_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = uart_rx_fifo_read_ctrl_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  processor_clk,
    input  logic                  reset,
    input  logic                  comp_empty,
    output logic [ADDR_WIDTH-1:0] r_add,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pop_count
);
    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] r_add_q, r_add_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [CNT_WIDTH-1:0]  pop_q, pop_d;
    logic                  rd_en;

    always_comb begin
        rd_en    = reset && !comp_empty && (state_q == EMPTY || (state_q == FULL && m_ready));
        state_d  = state_q;
        r_add_d  = rd_en ? r_add_q + 1'b1 : r_add_q;
        m_data_d = m_data_q;
        pop_d    = pop_q;
        case (state_q)
            EMPTY:   state_d = rd_en ? WAIT_RD : EMPTY;
            WAIT_RD: begin
                state_d  = FULL;
                m_data_d = mem_rdata;
            end
            FULL: if (m_ready) begin
                state_d = rd_en ? WAIT_RD : EMPTY;
                pop_d   = pop_q + 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge processor_clk) begin
        if (!reset) begin
            state_q  <= EMPTY;
            r_add_q  <= '0;
            m_data_q <= '0;
            pop_q    <= '0;
        end else begin
            state_q  <= state_d;
            r_add_q  <= r_add_d;
            m_data_q <= m_data_d;
            pop_q    <= pop_d;
        end
    end

    assign r_add     = r_add_q;
    assign mem_rd_en = rd_en;
    assign m_data    = m_data_q;
    assign m_valid   = state_q == FULL;
    assign pop_count = pop_q;
endmodule

// File: tb/tb_uart_rx_fifo_read_ctrl.sv
// tb_uart_rx_fifo_read_ctrl: directed and random checks of the read controller against a queue-based FIFO model
module tb_uart_rx_fifo_read_ctrl;
    logic        processor_clk = 0;
    logic        reset = 0;
    logic        comp_empty;
    logic [3:0]  r_add, r_add_s;
    logic        mem_rd_en, rd_s;
    logic [7:0]  mem_rdata, m_data, m_data_s;
    logic        m_valid, valid_s;
    logic        m_ready = 0;
    logic [15:0] pop_count;
    logic [2:0]  pop_small;

    logic [7:0]  ram [16];
    logic [3:0]  wptr = 0;
    logic [7:0]  fq [$];
    int          errors = 0, checks = 0;

    int          exp_radd = 0, exp_pops = 0;
    bit          exp_valid = 0, pend = 0, mon_en = 0;
    logic [7:0]  cur, fetched;

    always #5 processor_clk = ~processor_clk;

    assign comp_empty = (r_add == wptr);

    always @(posedge processor_clk) if (mem_rd_en) mem_rdata <= ram[r_add];

    uart_rx_fifo_read_ctrl dut (
        .processor_clk(processor_clk), .reset(reset), .comp_empty(comp_empty),
        .r_add(r_add), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .pop_count(pop_count)
    );

    uart_rx_fifo_read_ctrl #(.CNT_WIDTH(3)) dut_s (
        .processor_clk(processor_clk), .reset(reset), .comp_empty(comp_empty),
        .r_add(r_add_s), .mem_rd_en(rd_s), .mem_rdata(mem_rdata),
        .m_data(m_data_s), .m_valid(valid_s), .m_ready(m_ready), .pop_count(pop_small)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock: inputs change just after the rising edge, returns at the falling edge
    task automatic step(input bit push, input logic [7:0] b, input bit rdy, input bit rst_n, output bit pushed);
        @(posedge processor_clk);
        #1;
        reset = rst_n;
        m_ready = rdy;
        pushed = 0;
        if (!rst_n) begin
            wptr = 0;
            fq.delete();
        end
        if (push && (wptr - r_add) != 4'd15) begin
            ram[wptr] = b;
            wptr = wptr + 1'b1;
            fq.push_back(b);
            pushed = 1;
        end
        @(negedge processor_clk);
    endtask

    // reference: words leave in write order, a read needs a non-empty FIFO and a free output slot,
    // data appears two cycles after its read, and the slot empties only on a transfer
    always @(negedge processor_clk) if (mon_en) begin
        bit er;
        er = reset && fq.size() != 0 && (exp_valid ? m_ready : !pend);
        check("rd_en", mem_rd_en, er);
        check("valid", m_valid, exp_valid);
        if (exp_valid) check("data", m_data, cur);
        check("r_add", r_add, exp_radd[3:0]);
        check("pop", pop_count, exp_pops[15:0]);
        check("pop_small", pop_small, exp_pops[2:0]);
        if (!reset) begin
            exp_radd = 0; exp_pops = 0; exp_valid = 0; pend = 0;
        end else begin
            if (exp_valid && m_ready) exp_pops++;
            exp_valid = pend || (exp_valid && !m_ready);
            if (pend) cur = fetched;
            pend = er;
            if (er) begin
                fetched = fq.pop_front();
                exp_radd++;
            end
        end
    end

    initial begin
        bit p, found;
        int n;
        logic [7:0] w;
        repeat (3) begin
            step(1, 8'h77, 0, 0, p);
            check("rst_rd_en", mem_rd_en, 0);
            check("rst_radd", r_add, 0);
            check("rst_valid", m_valid, 0);
            check("rst_pop", pop_count, 0);
        end
        mon_en = 1;
        step(0, 0, 1, 0, p);
        step(1, 8'hA5, 1, 1, p);
        check("sw_rd_en", mem_rd_en, 1);
        step(0, 0, 1, 1, p);
        check("sw_radd", r_add, 1);
        check("sw_wait_valid", m_valid, 0);
        step(0, 0, 1, 1, p);
        check("sw_valid", m_valid, 1);
        check("sw_data", m_data, 8'hA5);
        step(0, 0, 1, 1, p);
        check("sw_after_valid", m_valid, 0);
        check("sw_pop", pop_count, 1);
        step(1, 8'h3C, 0, 1, p);
        step(1, 8'h55, 0, 1, p);
        step(1, 8'h66, 0, 1, p);
        repeat (10) begin
            step(0, 0, 0, 1, p);
            check("bp_data", m_data, 8'h3C);
            check("bp_valid", m_valid, 1);
            check("bp_rd_en", mem_rd_en, 0);
            check("bp_radd", r_add, 2);
        end
        step(0, 0, 1, 1, p);
        check("bp_release_rd", mem_rd_en, 1);
        step(0, 0, 1, 1, p);
        check("bp_pop", pop_count, 2);
        step(0, 0, 1, 0, p);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            w = 8'h10 + 8'(n % 16);
            step(n < 17, w, 1, 1, p);
            if (p) n++;
        end
        check("wrap_pop", pop_count, 17);
        step(0, 0, 1, 0, p);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step(1, 8'($urandom), 1, 1, p);
            found = mem_rd_en && r_add == 4'd5;
        end
        check("midrst_found", found, 1);
        step(0, 0, 1, 1, p);
        check("midrst_wait_radd", r_add, 6);
        step(0, 0, 1, 0, p);
        step(0, 0, 1, 1, p);
        check("midrst_valid", m_valid, 0);
        check("midrst_radd", r_add, 0);
        check("midrst_pop", pop_count, 0);
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 199) != 0, p);
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_read_ctrl.md
Name: uart_rx_fifo_read_ctrl

Overview:
- Read-side controller of the UART-to-processor async FIFO. Runs entirely in the processor clock domain.
- Owns the FIFO read pointer `r_add`. The downstream empty comparator compares `r_add` against the synchronized write pointer and returns `comp_empty` to this block.
- Issues synchronous reads to the dual-port RAM and presents words to the processor on a valid/ready interface through a one-entry output register.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; depth = 2^ADDR_WIDTH; matches ADDR_W.
- DATA_WIDTH, 8, FIFO word width (one UART byte).
- CNT_WIDTH, 16, width of the popped-word counter.

Ports:
- processor_clk  in  1  processor clock; the only clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of processor_clk.
- comp_empty  in  1  from the empty comparator; 1 when `r_add` equals the synchronized write pointer.
- r_add  out  ADDR_WIDTH  read pointer; feeds the comparator and the RAM read address.
- mem_rd_en  out  1  RAM read enable; the RAM returns data one cycle later.
- mem_rdata  in  DATA_WIDTH  RAM read data; valid the cycle after mem_rd_en.
- m_data  out  DATA_WIDTH  word presented to the processor.
- m_valid  out  1  m_data holds an unconsumed word.
- m_ready  in  1  processor accepts m_data; a transfer occurs when m_valid && m_ready.
- pop_count  out  CNT_WIDTH  count of completed transfers; wraps.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=EMPTY, r_add=0, m_data=0, m_valid=0, pop_count=0.
  - mem_rd_en is forced to 0 while reset is low.
- FSM states: EMPTY, WAIT_RD, FULL.
- EMPTY:
  - m_valid=0.
  - If comp_empty==0: mem_rd_en=1 (combinational), r_add<=r_add+1, next state WAIT_RD.
  - Otherwise stay in EMPTY with mem_rd_en=0.
- WAIT_RD:
  - m_data<=mem_rdata, next state FULL.
  - m_valid=0 in this state.
  - comp_empty and m_ready are ignored.
- FULL:
  - m_valid=1 and m_data is held stable.
  - On m_ready==1: transfer occurs, pop_count<=pop_count+1.
    - If comp_empty==0 in the same cycle: mem_rd_en=1, r_add<=r_add+1, next state WAIT_RD.
    - Otherwise next state EMPTY.
  - On m_ready==0: stay in FULL and issue no read, even if the FIFO is non-empty.
- m_valid is a registered state decode: 1 iff state==FULL. It never drops without a transfer.
- mem_rd_en = reset && !comp_empty && ((state==EMPTY) || (state==FULL && m_ready)).
- The RAM read address equals r_add before the increment in the cycle mem_rd_en is high.
- comp_empty is combinational from r_add, so it reflects the new r_add in the cycle after an increment. No stale-flag guard is needed.
- r_add wraps from 2^ADDR_WIDTH-1 to 0 by modulo arithmetic. pop_count wraps from all-ones to 0.
- Latency: a word becomes readable in EMPTY at cycle t, giving mem_rd_en at t and m_valid=1 at t+2.
- Throughput: at most one word per 2 cycles. This is sufficient for UART rates.
- Underflow is impossible: a read is issued only when comp_empty==0.
- Reset during WAIT_RD or FULL: the in-flight word is discarded and r_add returns to 0. The write side must be reset in the same system reset so the pointers stay consistent.
- m_ready while m_valid==0 has no effect.

Decomposition:
- DataTypes package:
  - ADDR_W (logic [ADDR_WIDTH-1:0]), DATA_T (logic [DATA_WIDTH-1:0]), bit_t.
  - rd_state_t enum {EMPTY, WAIT_RD, FULL}.
  - Constants ADDR_WIDTH and DATA_WIDTH.
- No sub-module is needed. The pointer register, FSM and output register form one flat block.
- At the next level up, this block is instantiated beside uartToProcessorComp and the dual-port RAM.

Test Plan:
- Reset: hold reset=0 for 3 cycles with comp_empty=0 → mem_rd_en=0, r_add=0, m_valid=0, pop_count=0 throughout.
- Single word: RAM[0]=0xA5, comp_empty drops at cycle 5 and m_ready=1:
  - Cycle 5: mem_rd_en=1.
  - Cycle 6: r_add=1.
  - Cycle 7: m_valid=1, m_data=0xA5; transfer occurs.
  - Cycle 8: with comp_empty=1, m_valid=0 and pop_count=1.
- Backpressure: word 0x3C in FULL, m_ready=0 for 10 cycles, comp_empty=0 → m_data stays 0x3C, m_valid stays 1, mem_rd_en=0, r_add unchanged. Raising m_ready gives one transfer and mem_rd_en=1 in that same cycle.
- Wrap: fill RAM 0..15 with 0x10..0x1F, keep comp_empty=0, and stream 17 words with m_ready=1:
  - Words arrive in order 0x10..0x1F, then 0x10 again.
  - r_add goes 15→0.
  - m_valid follows the pattern 1-0-1-0.
  - Final pop_count=17.
- Reset mid-operation: assert reset=0 in WAIT_RD with r_add=6 → next cycle state=EMPTY, m_valid=0, r_add=0, pop_count=0, and the fetched word is never presented.
- pop_count wrap: force 65535 completed transfers, then one more → pop_count=0.
